regfile_write_sequencer: RTL and testbench

- Owns the single write port of the 32x32 integer register file and sits directly upstream of it.
- After reset, and on request, sweeps x1..x31 to a known init value. Otherwise forwards core writeback requests through a valid/ready handshake.
- All register-file-facing outputs are registered, so the file always sees clean, glitch-free we/address/data.
- Also counts committed architectural writes for the performance/debug CSR path.

---
 rtl/regfile_write_sequencer.sv | 125 ++++++++++++
 tb/tb_regfile_write_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_sequencer.sv
// ---------------------------------------------------------------------------
// regfile_write_sequencer
//
// Sole owner of the integer register file's write port. Out of reset, and
// whenever clear_req is pulsed while running, it sweeps x1..x(NREGS-1) to
// INIT_VALUE, one register per cycle. Otherwise it forwards core writeback
// requests accepted through a valid/ready handshake. Every register-file
// facing output comes straight from a flop so the file sees clean
// we/address/data. wr_count tallies committed writeback writes; clear-sweep
// writes and dropped x0 writes are not counted.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset (wins over everything)
//   wb_valid   writeback request valid
//   wb_ready   writeback request accepted when wb_valid && wb_ready
//   wb_addr    writeback destination register
//   wb_data    writeback destination data
//   clear_req  single-cycle pulse, starts a clear sweep (ignored mid-sweep)
//   init_done  high while in RUN
//   rf_we      register-file write enable
//   rf_A3      register-file write address
//   rf_wd      register-file write data
//   wr_count   committed writeback writes, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module regfile_write_sequencer #(
  parameter int               NREGS      = 32,
  parameter int               XLEN       = 32,
  parameter logic [XLEN-1:0]  INIT_VALUE = '0,
  parameter int               CNT_W      = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wb_valid,
  output logic                       wb_ready,
  input  logic [$clog2(NREGS)-1:0]   wb_addr,
  input  logic [XLEN-1:0]            wb_data,
  input  logic                       clear_req,
  output logic                       init_done,
  output logic                       rf_we,
  output logic [$clog2(NREGS)-1:0]   rf_A3,
  output logic [XLEN-1:0]            rf_wd,
  output logic [CNT_W-1:0]           wr_count
);

  localparam int AW = $clog2(NREGS);
  localparam logic [AW-1:0] LAST_IDX  = AW'(NREGS - 1);
  localparam logic [AW-1:0] FIRST_IDX = AW'(1);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t            state_reg;
  logic [AW-1:0]     idx_reg;
  logic              rf_we_reg;
  logic [AW-1:0]     rf_a3_reg;
  logic [XLEN-1:0]   rf_wd_reg;
  logic              init_done_reg;
  logic [CNT_W-1:0]  wr_count_reg;

  // A clear request takes priority over a same-cycle writeback, so ready is
  // withheld in that cycle and the writeback stays pending upstream.
  assign wb_ready = (state_reg == RUN) && !clear_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= CLEAR;
      idx_reg       <= FIRST_IDX;
      rf_we_reg     <= 1'b0;
      rf_a3_reg     <= '0;
      rf_wd_reg     <= '0;
      init_done_reg <= 1'b0;
      wr_count_reg  <= '0;
    end else begin
      case (state_reg)
        CLEAR: begin
          // Sweep never touches x0; idx starts at 1 and stops at NREGS-1.
          rf_we_reg <= 1'b1;
          rf_a3_reg <= idx_reg;
          rf_wd_reg <= INIT_VALUE;
          if (idx_reg == LAST_IDX) begin
            state_reg     <= RUN;
            init_done_reg <= 1'b1;
            idx_reg       <= FIRST_IDX;
          end else begin
            idx_reg <= idx_reg + FIRST_IDX;
          end
        end

        RUN: begin
          if (clear_req) begin
            state_reg     <= CLEAR;
            idx_reg       <= FIRST_IDX;
            init_done_reg <= 1'b0;
            rf_we_reg     <= 1'b0;
          end else if (wb_valid && (wb_addr != '0)) begin
            rf_we_reg    <= 1'b1;
            rf_a3_reg    <= wb_addr;
            rf_wd_reg    <= wb_data;
            wr_count_reg <= wr_count_reg + CNT_W'(1);
          end else begin
            // Idle, or an x0 write that is accepted and silently dropped.
            // Address/data hold their last values.
            rf_we_reg <= 1'b0;
          end
        end

        default: begin
          state_reg <= CLEAR;
          idx_reg   <= FIRST_IDX;
          rf_we_reg <= 1'b0;
        end
      endcase
    end
  end

  assign rf_we     = rf_we_reg;
  assign rf_A3     = rf_a3_reg;
  assign rf_wd     = rf_wd_reg;
  assign init_done = init_done_reg;
  assign wr_count  = wr_count_reg;

endmodule

// File: tb/tb_regfile_write_sequencer.sv
// ---------------------------------------------------------------------------
// tb_regfile_write_sequencer
//
// Bench for regfile_write_sequencer. The reference model is a queue of
// register-file writes that still have to be presented, one per clock edge:
// reset loads it with the x1..x(N-1) sweep, a clear in RUN loads a bubble
// followed by the sweep, and an accepted writeback appends its write. The
// DUT is running exactly when that queue is empty. A single compare process
// checks registered outputs on every falling edge and wb_ready just before
// each rising edge; directed sections add literal expectations on top.
// ---------------------------------------------------------------------------
module tb_regfile_write_sequencer;

  localparam int          NREGS = 32;
  localparam int          XLEN  = 32;
  localparam int          CNT_W = 5;
  localparam int          AW    = 5;
  localparam logic [31:0] INIT  = 32'h0;

  logic             clk = 1'b0;
  logic             reset;
  logic             wb_valid;
  logic             wb_ready;
  logic [AW-1:0]    wb_addr;
  logic [XLEN-1:0]  wb_data;
  logic             clear_req;
  logic             init_done;
  logic             rf_we;
  logic [AW-1:0]    rf_A3;
  logic [XLEN-1:0]  rf_wd;
  logic [CNT_W-1:0] wr_count;

  regfile_write_sequencer #(
    .NREGS(NREGS), .XLEN(XLEN), .INIT_VALUE(INIT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_addr(wb_addr), .wb_data(wb_data),
    .clear_req(clear_req), .init_done(init_done),
    .rf_we(rf_we), .rf_A3(rf_A3), .rf_wd(rf_wd),
    .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          we;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         pend_q[$];
  bit          model_valid = 1'b0;
  bit          exp_we;
  logic [4:0]  exp_a3;
  logic [31:0] exp_wd;
  bit          exp_init;
  int          exp_cnt;
  bit          exp_ready;

  int n_vec = 0;
  int n_cmp = 0;
  int n_err = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  task automatic push_sweep();
    for (int i = 1; i < NREGS; i++) begin
      wr_t e;
      e.we = 1'b1; e.addr = 5'(i); e.data = INIT;
      pend_q.push_back(e);
    end
  endtask

  // Advance the model across one rising edge with the inputs that were applied.
  task automatic model_step(input bit r, input bit v, input logic [4:0] a,
                            input logic [31:0] d, input bit c);
    wr_t e;
    if (r) begin
      pend_q.delete();
      push_sweep();
      exp_we = 0; exp_a3 = '0; exp_wd = '0; exp_init = 0; exp_cnt = 0;
      model_valid = 1'b1;
      return;
    end
    if (pend_q.size() == 0) begin
      if (c) begin
        e.we = 1'b0; e.addr = '0; e.data = '0;
        pend_q.push_back(e);
        push_sweep();
      end else if (v && a != 0) begin
        e.we = 1'b1; e.addr = a; e.data = d;
        pend_q.push_back(e);
        exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
      end
    end
    if (pend_q.size() > 0) begin
      e = pend_q.pop_front();
      exp_we = e.we;
      if (e.we) begin
        exp_a3 = e.addr;
        exp_wd = e.data;
      end
    end else begin
      exp_we = 1'b0;
    end
    exp_init = (pend_q.size() == 0);
  endtask

  task automatic step(input bit r, input bit v, input logic [4:0] a,
                      input logic [31:0] d, input bit c);
    reset = r; wb_valid = v; wb_addr = a; wb_data = d; clear_req = c;
    exp_ready = (pend_q.size() == 0) && !c;
    n_vec++;
    @(posedge clk);
    model_step(r, v, a, d, c);
    @(negedge clk);
    #1;
  endtask

  // Single compare process: registered outputs at the falling edge,
  // combinational ready just before the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (model_valid) begin
        chk("rf_we",     rf_we,     exp_we);
        chk("rf_A3",     rf_A3,     exp_a3);
        chk("rf_wd",     rf_wd,     exp_wd);
        chk("init_done", init_done, exp_init);
        chk("wr_count",  wr_count,  exp_cnt);
      end
      #3;
      if (model_valid) chk("wb_ready", wb_ready, exp_ready);
    end
  end

  initial begin
    reset = 1'b1; wb_valid = 0; wb_addr = '0; wb_data = '0; clear_req = 0;

    // Reset state.
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("lit_rst_we", rf_we, 0);
    chk("lit_rst_init", init_done, 0);
    chk("lit_rst_cnt", wr_count, 0);
    chk("lit_rst_ready", wb_ready, 0);

    // Power-up sweep with wb_valid held high.
    for (int k = 1; k <= 31; k++) begin
      step(0, 1, 5'd9, 32'hCAFE0000 + k, 0);
      chk("lit_sweep_we", rf_we, 1);
      chk("lit_sweep_a3", rf_A3, k);
      chk("lit_sweep_wd", rf_wd, 0);
      chk("lit_sweep_init", init_done, (k == 31));
      chk("lit_sweep_ready", wb_ready, (k == 31));
    end

    // Single write to x5.
    step(0, 1, 5'd5, 32'hDEADBEEF, 0);
    chk("lit_x5_we", rf_we, 1);
    chk("lit_x5_a3", rf_A3, 5);
    chk("lit_x5_wd", rf_wd, 32'hDEADBEEF);
    chk("lit_x5_cnt", wr_count, 1);
    step(0, 0, 0, 0, 0);
    chk("lit_x5_idle_we", rf_we, 0);

    // x0 write is accepted and dropped.
    step(0, 1, 5'd0, 32'h12345678, 0);
    chk("lit_x0_we", rf_we, 0);
    chk("lit_x0_cnt", wr_count, 1);

    // Back-to-back x1, x2, x3.
    for (int k = 1; k <= 3; k++) begin
      step(0, 1, 5'(k), 32'h1000 + k, 0);
      chk("lit_b2b_we", rf_we, 1);
      chk("lit_b2b_a3", rf_A3, k);
    end
    chk("lit_b2b_cnt", wr_count, 4);
    step(0, 0, 0, 0, 0);

    // clear_req collides with a writeback to x7.
    step(0, 1, 5'd7, 32'h77777777, 1);
    chk("lit_clr_we", rf_we, 0);
    chk("lit_clr_init", init_done, 0);
    chk("lit_clr_cnt", wr_count, 4);
    for (int k = 1; k <= 31; k++) begin
      step(0, 0, 0, 0, (k == 5));  // a clear mid-sweep must not restart it
      chk("lit_csweep_a3", rf_A3, k);
      chk("lit_csweep_wd", rf_wd, 0);
    end
    chk("lit_csweep_init", init_done, 1);

    // Reset in the middle of a sweep, held for two cycles.
    step(0, 0, 0, 0, 1);
    for (int k = 1; k <= 10; k++) step(0, 0, 0, 0, 0);
    chk("lit_mid_a3", rf_A3, 10);
    step(1, 1, 5'd3, 32'h3, 0);
    step(1, 1, 5'd3, 32'h3, 0);
    chk("lit_mid_rst_we", rf_we, 0);
    chk("lit_mid_rst_init", init_done, 0);
    for (int k = 1; k <= 31; k++) begin
      step(0, 0, 0, 0, 0);
      chk("lit_rsweep_we", rf_we, 1);
      chk("lit_rsweep_a3", rf_A3, k);
    end
    chk("lit_rsweep_init", init_done, 1);

    // Randomised traffic; wr_count wraps at 2^CNT_W along the way.
    for (int n = 0; n < 3000; n++) begin
      bit          r, v, c;
      logic [4:0]  a;
      logic [31:0] d;
      r = ($urandom_range(0, 299) == 0);
      c = ($urandom_range(0, 39) == 0);
      v = ($urandom_range(0, 3) != 0);
      a = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      d = $urandom;
      step(r, v, a, d, c);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
